// File: rtl/uart_sel_pkg.sv
// Shared types and ASCII constants for the UART console selector.
package uart_sel_pkg;

   typedef enum logic [2:0] {
      RxIdle,
      RxStart,
      RxData,
      RxStop,
      RxWaitHigh
   } rx_state_e;

   typedef enum logic {
      PIdle,
      PEsc
   } parse_state_e;

   localparam logic [7:0] CHAR_0    = 8'h30;
   localparam logic [7:0] CHAR_9    = 8'h39;
   localparam logic [7:0] CHAR_PLUS = 8'h2B;

endpackage

// File: rtl/uart_sel_rx.sv
// 8N1 receiver for the snooped host line: 2-flop synchronizer, mid-bit sampling, break handling.
module uart_sel_rx
   import uart_sel_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 250000000,
   parameter int unsigned BAUD        = 115200
) (
   input  logic       shell_clk,
   input  logic       shell_rst_n,
   input  logic       shell_tx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int unsigned BIT_CYC = CLK_FREQ_HZ / BAUD;
   localparam int unsigned HALF    = BIT_CYC / 2;
   localparam int unsigned CNT_W   = $clog2(BIT_CYC);

   // Reload values are one less than the interval since expiry is detected at zero.
   localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYC - 1);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);

   logic [1:0]       sync_q, sync_d;
   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             rx_s;
   logic             tick;

   assign rx_s      = sync_q[1];
   assign tick      = (cnt_q == '0);
   assign byte_data = shift_q;

   always_comb begin
      sync_d     = {sync_q[0], shell_tx};
      state_d    = state_q;
      cnt_d      = tick ? cnt_q : cnt_q - CNT_W'(1);
      bit_d      = bit_q;
      shift_d    = shift_q;
      byte_valid = 1'b0;
      frame_err  = 1'b0;

      unique case (state_q)
         // Idle is only ever entered with rx_s high, so a low level here is a falling edge.
         RxIdle: begin
            if (!rx_s) begin
               cnt_d   = HALF_LOAD;
               state_d = RxStart;
            end
         end
         RxStart: begin
            if (tick) begin
               if (!rx_s) begin
                  cnt_d   = BIT_LOAD;
                  bit_d   = 3'd0;
                  state_d = RxData;
               end else begin
                  state_d = RxIdle;
               end
            end
         end
         RxData: begin
            if (tick) begin
               shift_d = {rx_s, shift_q[7:1]};
               cnt_d   = BIT_LOAD;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = RxStop;
               end
            end
         end
         RxStop: begin
            if (tick) begin
               if (rx_s) begin
                  byte_valid = 1'b1;
                  state_d    = RxIdle;
               end else begin
                  frame_err = 1'b1;
                  state_d   = RxWaitHigh;
               end
            end
         end
         RxWaitHigh: begin
            if (rx_s) begin
               state_d = RxIdle;
            end
         end
         default: state_d = RxIdle;
      endcase
   end

   always_ff @(posedge shell_clk or negedge shell_rst_n) begin
      if (!shell_rst_n) begin
         sync_q  <= 2'b11;
         state_q <= RxIdle;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/uart_console_selector.sv
// Snoops the host serial line and decodes ESC+digit / ESC+'+' into a console-select index.
// Optional escape timeout enabled by defining UART_SEL_TIMEOUT_EN.
module uart_console_selector
   import uart_sel_pkg::*;
#(
   parameter int unsigned PITON_N      = 4,
   parameter int unsigned PITON_N_LOG  = 2,
   parameter int unsigned CLK_FREQ_HZ  = 250000000,
   parameter int unsigned BAUD         = 115200,
   parameter logic [7:0]  ESC_CHAR     = 8'h01,
   parameter int unsigned TIMEOUT_BITS = 20
) (
   input  logic                   shell_clk,
   input  logic                   shell_rst_n,
   input  logic                   shell_tx,
   output logic [PITON_N_LOG-1:0] sw,
   output logic                   sw_changed,
   output logic                   frame_err
);

   if ((2 ** PITON_N_LOG) < PITON_N || TIMEOUT_BITS == 0) begin : g_bad_param
      $error("uart_console_selector: PITON_N_LOG too small or TIMEOUT_BITS zero");
   end

   logic [7:0]             byte_data;
   logic                   byte_valid;
   logic                   rx_frame_err;
   parse_state_e           pstate_q, pstate_d;
   logic [PITON_N_LOG-1:0] sw_q, sw_d;
   logic                   sw_changed_q, sw_changed_d;
   logic [7:0]             digit;
   logic                   is_digit;

   uart_sel_rx #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ),
      .BAUD       (BAUD)
   ) u_rx (
      .shell_clk  (shell_clk),
      .shell_rst_n(shell_rst_n),
      .shell_tx   (shell_tx),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .frame_err  (rx_frame_err)
   );

`ifdef UART_SEL_TIMEOUT_EN
   localparam int unsigned TOUT_CYC = TIMEOUT_BITS * (CLK_FREQ_HZ / BAUD);
   localparam int unsigned TOUT_W   = $clog2(TOUT_CYC + 1);

   logic [TOUT_W-1:0] tmo_q, tmo_d;
   logic              tmo_expired;

   // Held at zero outside P_ESC, so it starts from zero on every entry.
   assign tmo_d       = (pstate_q == PEsc) ? tmo_q + TOUT_W'(1) : '0;
   assign tmo_expired = (pstate_q == PEsc) && (tmo_q == TOUT_W'(TOUT_CYC - 1));

   always_ff @(posedge shell_clk or negedge shell_rst_n) begin
      if (!shell_rst_n) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   assign digit    = byte_data - CHAR_0;
   assign is_digit = (byte_data >= CHAR_0) && (byte_data <= CHAR_9);

   always_comb begin
      pstate_d = pstate_q;
      sw_d     = sw_q;

      if (rx_frame_err) begin
         pstate_d = PIdle;
      end else if (byte_valid) begin
         unique case (pstate_q)
            PIdle: begin
               if (byte_data == ESC_CHAR) begin
                  pstate_d = PEsc;
               end
            end
            PEsc: begin
               pstate_d = PIdle;
               if (is_digit) begin
                  if (32'(digit) < PITON_N) begin
                     sw_d = PITON_N_LOG'(digit);
                  end
               end else if (byte_data == CHAR_PLUS) begin
                  sw_d = (32'(sw_q) == PITON_N - 1) ? '0 : sw_q + PITON_N_LOG'(1);
               end
            end
            default: pstate_d = PIdle;
         endcase
`ifdef UART_SEL_TIMEOUT_EN
      end else if (tmo_expired) begin
         pstate_d = PIdle;
`endif
      end

      sw_changed_d = (sw_d != sw_q);
   end

   always_ff @(posedge shell_clk or negedge shell_rst_n) begin
      if (!shell_rst_n) begin
         pstate_q     <= PIdle;
         sw_q         <= '0;
         sw_changed_q <= 1'b0;
      end else begin
         pstate_q     <= pstate_d;
         sw_q         <= sw_d;
         sw_changed_q <= sw_changed_d;
      end
   end

   assign sw         = sw_q;
   assign sw_changed = sw_changed_q;
   assign frame_err  = rx_frame_err;

endmodule

// File: tb/tb_uart_console_selector.sv
// Self-checking bench: directed vector table, hand sequences, and random bytes vs. a model.
module tb_uart_console_selector;

   localparam int unsigned PITON_N     = 4;
   localparam int unsigned PITON_N_LOG = 2;
   localparam int unsigned CLK_HZ      = 1600;
   localparam int unsigned BAUD_R      = 100;
   localparam int unsigned BIT         = CLK_HZ / BAUD_R;

   logic                   clk;
   logic                   rst_n;
   logic                   tx;
   logic [PITON_N_LOG-1:0] sw;
   logic                   sw_changed;
   logic                   frame_err;

   int n_vec;
   int n_err;
   int ch_cnt;
   int fe_cnt;

   // Model state: selected index and whether an escape is pending.
   int m_sw;
   bit m_esc;

   typedef struct {
      logic [7:0] b;
      logic       ok;
      int         sw;
      int         ch;
      int         fe;
   } vec_t;

   vec_t tbl[22];

   uart_console_selector #(
      .PITON_N     (PITON_N),
      .PITON_N_LOG (PITON_N_LOG),
      .CLK_FREQ_HZ (CLK_HZ),
      .BAUD        (BAUD_R),
      .ESC_CHAR    (8'h01),
      .TIMEOUT_BITS(20)
   ) dut (
      .shell_clk  (clk),
      .shell_rst_n(rst_n),
      .shell_tx   (tx),
      .sw         (sw),
      .sw_changed (sw_changed),
      .frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sw_changed) ch_cnt++;
      if (frame_err) fe_cnt++;
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic hold(input int cycles, input logic v);
      tx = v;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic ok);
      hold(BIT, 1'b0);
      for (int i = 0; i < 8; i++) hold(BIT, b[i]);
      hold(BIT, ok);
      if (!ok) hold(BIT, 1'b1);
   endtask

   task automatic apply(input string name, input logic [7:0] b, input logic ok,
                        input int exp_sw, input int exp_ch, input int exp_fe);
      int ch0;
      int fe0;
      ch0 = ch_cnt;
      fe0 = fe_cnt;
      send_byte(b, ok);
      #1;
      check({name, " sw"}, int'(sw), exp_sw);
      check({name, " sw_changed pulses"}, ch_cnt - ch0, exp_ch);
      check({name, " frame_err pulses"}, fe_cnt - fe0, exp_fe);
   endtask

   // Spec-level effect of one received byte on the model.
   task automatic model_byte(input logic [7:0] b, input logic ok, output int ch, output int fe);
      int nsw;
      nsw = m_sw;
      fe  = 0;
      if (!ok) begin
         m_esc = 0;
         fe    = 1;
      end else if (m_esc) begin
         m_esc = 0;
         if (b >= 8'h30 && b <= 8'h39 && int'(b) - 48 < PITON_N) nsw = int'(b) - 48;
         else if (b == 8'h2B) nsw = (m_sw + 1) % PITON_N;
      end else if (b == 8'h01) begin
         m_esc = 1;
      end
      ch   = (nsw != m_sw) ? 1 : 0;
      m_sw = nsw;
   endtask

   initial begin
      int exp_ch;
      int exp_fe;
      int ch0;
      int fe0;
      logic [7:0] rb;
      logic rok;
      int r;

      n_vec  = 0;
      n_err  = 0;
      ch_cnt = 0;
      fe_cnt = 0;

      tbl[0]  = '{8'h01, 1'b1, 0, 0, 0};
      tbl[1]  = '{8'h32, 1'b1, 2, 1, 0};
      tbl[2]  = '{8'h01, 1'b1, 2, 0, 0};
      tbl[3]  = '{8'h2B, 1'b1, 3, 1, 0};
      tbl[4]  = '{8'h01, 1'b1, 3, 0, 0};
      tbl[5]  = '{8'h2B, 1'b1, 0, 1, 0};
      tbl[6]  = '{8'h01, 1'b1, 0, 0, 0};
      tbl[7]  = '{8'h37, 1'b1, 0, 0, 0};
      tbl[8]  = '{8'h01, 1'b0, 0, 0, 1};
      tbl[9]  = '{8'h31, 1'b1, 0, 0, 0};
      tbl[10] = '{8'h01, 1'b1, 0, 0, 0};
      tbl[11] = '{8'h01, 1'b1, 0, 0, 0};
      tbl[12] = '{8'h31, 1'b1, 0, 0, 0};
      tbl[13] = '{8'h61, 1'b1, 0, 0, 0};
      tbl[14] = '{8'h01, 1'b1, 0, 0, 0};
      tbl[15] = '{8'h31, 1'b1, 1, 1, 0};
      tbl[16] = '{8'h01, 1'b1, 1, 0, 0};
      tbl[17] = '{8'h31, 1'b1, 1, 0, 0};
      tbl[18] = '{8'h01, 1'b1, 1, 0, 0};
      tbl[19] = '{8'h33, 1'b1, 3, 1, 0};
      tbl[20] = '{8'h01, 1'b1, 3, 0, 0};
      tbl[21] = '{8'h30, 1'b1, 0, 1, 0};

      // Reset and idle line.
      tx    = 1'b1;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("reset sw", int'(sw), 0);
      check("reset sw_changed", int'(sw_changed), 0);
      check("reset frame_err", int'(frame_err), 0);
      rst_n = 1'b1;
      hold(5 * BIT, 1'b1);
      #1;
      check("idle sw", int'(sw), 0);
      check("idle pulses", ch_cnt + fe_cnt, 0);

      for (int i = 0; i < 22; i++) begin
         apply($sformatf("tbl[%0d]", i), tbl[i].b, tbl[i].ok, tbl[i].sw, tbl[i].ch, tbl[i].fe);
      end

      // Line break for three byte-times: one framing error, no byte.
      fe0 = fe_cnt;
      hold(30 * BIT, 1'b0);
      hold(2 * BIT, 1'b1);
      #1;
      check("break frame_err pulses", fe_cnt - fe0, 1);
      check("break sw", int'(sw), 0);
      apply("post-break esc", 8'h01, 1'b1, 0, 0, 0);
      apply("post-break '1'", 8'h31, 1'b1, 1, 1, 0);

      // Quarter-bit glitch between ESC and digit must not be received as a byte.
      apply("glitch esc", 8'h01, 1'b1, 1, 0, 0);
      hold(BIT / 4, 1'b0);
      hold(2 * BIT, 1'b1);
      apply("glitch '2'", 8'h32, 1'b1, 2, 1, 0);

      // Escape followed by a long pause.
      apply("timeout esc", 8'h01, 1'b1, 2, 0, 0);
      hold(21 * BIT, 1'b1);
`ifdef UART_SEL_TIMEOUT_EN
      apply("timeout '3'", 8'h33, 1'b1, 2, 0, 0);
`else
      apply("timeout '3'", 8'h33, 1'b1, 3, 1, 0);
`endif

      // Reset mid-DATA after an escape: partial byte dropped, parser back to idle.
      apply("rst esc", 8'h01, 1'b1, int'(sw), 0, 0);
      hold(BIT, 1'b0);
      hold(BIT, 1'b1);
      hold(BIT, 1'b0);
      hold(BIT, 1'b0);
      rst_n = 1'b0;
      tx    = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      check("mid-byte reset sw", int'(sw), 0);
      rst_n = 1'b1;
      hold(2 * BIT, 1'b1);
      apply("post-reset '1'", 8'h31, 1'b1, 0, 0, 0);

      // Random traffic against the model.
      m_sw  = 0;
      m_esc = 0;
      for (int i = 0; i < 150; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 3) rb = 8'h01;
         else if (r < 6) rb = 8'h30 + 8'($urandom_range(0, 9));
         else if (r < 8) rb = 8'h2B;
         else rb = 8'($urandom_range(0, 255));
         rok = ($urandom_range(0, 15) != 0);
         model_byte(rb, rok, exp_ch, exp_fe);
         ch0 = ch_cnt;
         fe0 = fe_cnt;
         send_byte(rb, rok);
         #1;
         check($sformatf("rand[%0d] byte %02h sw", i, rb), int'(sw), m_sw);
         check($sformatf("rand[%0d] byte %02h sw_changed", i, rb), ch_cnt - ch0, exp_ch);
         check($sformatf("rand[%0d] byte %02h frame_err", i, rb), fe_cnt - fe0, exp_fe);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
